ulpi_link_buf: RTL and testbench
================================

Name: ulpi_link_buf

Overview:
- ULPI link-layer controller; next generation of ulpi_link.
- Adds a parametrised command FIFO with packet framing (stp generation) between the system command interface and the ULPI bus.
- Tracks bus turnaround; separates PHY RX CMD bytes from RX data bytes.
- Sits between system logic (ulpi_link_if side) and the external ULPI PHY (ulpi_if side).

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of two, at least 2.
- DATA_W, 8, ULPI data width; only 8 supported; elaborate-time assertion otherwise.

Ports:
- clk  in  1  ULPI 60 MHz clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  DATA_W  byte to queue for transmission.
- cmd_last  in  1  marks final byte of a packet.
- cmd_strobe  in  1  enqueue request.
- cmd_busy  out  1  FIFO full; strobe ignored while high.
- ulpi_dir  in  1  PHY owns bus when high.
- ulpi_nxt  in  1  PHY throttle / accept.
- ulpi_data_i  in  DATA_W  bus input.
- ulpi_data_o  out  DATA_W  bus output.
- ulpi_data_oe  out  1  link drives bus.
- ulpi_stp  out  1  end-of-packet strobe.
- rx_data  out  DATA_W  received USB data byte.
- rx_valid  out  1  rx_data valid, one cycle per byte.
- rx_cmd  out  DATA_W  last RX CMD byte; held until next RX CMD.
- rx_cmd_valid  out  1  one-cycle pulse on RX CMD update.
- rx_active  out  1  high while dir high, excluding turnaround cycles.

Behaviour:
Reset values:
- All outputs 0 at reset; ulpi_data_o = 8'h00.
- FIFO empty, state IDLE.
- Reset mid-packet discards the FIFO and the in-flight packet; no stp is issued.

Command FIFO:
- Entry is {cmd_last, cmd}.
- Enqueue when cmd_strobe && !cmd_busy.
- cmd_busy = full, registered, asserted the cycle after the write that fills the FIFO.
- Simultaneous push and pop when full is not allowed (busy blocks); push and pop in the same cycle when non-full is accepted and the count is unchanged.
- Pointers wrap modulo CMD_DEPTH, with an extra wrap bit for full/empty.

Bus state machine: IDLE, TX, STP, TURN_IN, RX, TURN_OUT.
- IDLE:
  - dir=1 -> TURN_IN.
  - Else if FIFO non-empty -> TX.
  - Drives oe=1, data 8'h00.
- TX:
  - Drives FIFO head, oe=1.
  - nxt=1: pop the entry. If cmd_last -> STP; else stay in TX with the next head. If the FIFO is empty at a non-last pop, drive 8'h00 and wait in TX.
  - nxt=0: hold the byte.
  - dir=1: -> TURN_IN; the head is not popped and is re-driven after return.
- STP:
  - ulpi_stp=1 and data 8'h00 for exactly one cycle, then IDLE.
  - dir rising during STP still completes the stp cycle, then goes to TURN_IN.
- TURN_IN:
  - Entered in the same cycle dir is sampled high; oe=0 that cycle.
  - Exactly one cycle, no RX decode; then RX if dir=1, else TURN_OUT.
- RX (oe=0):
  - nxt=1: rx_data <= data_i, rx_valid pulses.
  - nxt=0: rx_cmd <= data_i, rx_cmd_valid pulses.
  - dir=0 -> TURN_OUT.
- TURN_OUT:
  - One cycle with oe=0, then IDLE.
  - dir=1 during TURN_OUT goes directly back to RX without a second turnaround.

Other rules:
- ulpi_data_oe falls combinationally with dir; the link never drives while dir=1.
- RX decode latency: 1 cycle from sampled bus byte to rx_* outputs.

Decomposition:
- Package ulpi_pkg:
  - state enum ulpi_bus_state_t;
  - ULPI_IDLE_BYTE = 8'h00;
  - cmd_entry_t struct {last, data}.
- Sub-module ulpi_cmd_fifo (parametrised by CMD_DEPTH), with ports push, push_data, pop, head, empty, full.
- The FSM and RX decode stay in ulpi_link_buf.

Test Plan:
- Reset, then 3 idle cycles -> oe=1, data 8'h00, stp=0, cmd_busy=0, rx_valid=0.
- Queue 8'h41, 8'h55, 8'h66 (last on the third); PHY nxt pattern 1,0,1,1 -> bus shows 41,55,55,66; one-cycle stp follows; FIFO empty.
- dir rises while 8'h55 is held -> oe=0 the same cycle; one turnaround cycle; RX CMD 8'h4D raises rx_cmd_valid; dir falls, one idle turnaround; 8'h55 re-driven.
- With dir=1: nxt pattern 0,1,1,1,0 with bytes 4D,A1,A2,A3,4E -> rx_cmd_valid twice (4D, 4E); rx_valid three times (A1..A3).
- Fill CMD_DEPTH=4 entries with nxt held 0 -> cmd_busy=1; a fifth strobe is ignored; one nxt pulse -> cmd_busy=0 the next cycle.
- Assert reset during TX of a 3-byte packet -> outputs return to reset values at once; no stp; FIFO empty after release.

Source files
------------

// File: rtl/ulpi_pkg.sv
// ---------------------------------------------------------------------------
// ulpi_pkg
// Shared types and constants for the ULPI link layer with command buffering.
//   ulpi_bus_state_t : bus ownership / transfer state of the link FSM
//   ULPI_IDLE_BYTE   : value driven on the bus when the link has nothing to send
//   cmd_entry_t      : one queued command byte plus its end-of-packet flag
// ---------------------------------------------------------------------------
package ulpi_pkg;

    localparam int ULPI_W = 8;

    localparam logic [ULPI_W-1:0] ULPI_IDLE_BYTE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_STP,
        ST_TURN_IN,
        ST_RX,
        ST_TURN_OUT
    } ulpi_bus_state_t;

    typedef struct packed {
        logic              last;
        logic [ULPI_W-1:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/ulpi_cmd_fifo.sv
// ---------------------------------------------------------------------------
// ulpi_cmd_fifo
// Synchronous FIFO of command entries between the system side and the bus FSM.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   push        : write request; ignored while full
//   push_data   : entry to write
//   pop         : read request; ignored while empty
//   head        : entry at the read pointer (valid when !empty)
//   empty       : no entries stored
//   full        : registered full flag, rises the cycle after the filling write
// ---------------------------------------------------------------------------
module ulpi_cmd_fifo
    import ulpi_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  cmd_entry_t push_data,
    input  logic       pop,
    output cmd_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;

    if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ulpi_cmd_fifo: CMD_DEPTH must be a power of two and at least 2");
    end

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] rd_ptr_nxt;
    logic        do_push;
    logic        do_pop;

    cmd_entry_t mem [CMD_DEPTH];

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ulpi_link_buf.sv
// ---------------------------------------------------------------------------
// ulpi_link_buf
// ULPI link-layer controller with a buffered, packet-framed command path.
// Ports:
//   clk, reset          : 60 MHz ULPI clock, asynchronous active-high reset
//   cmd, cmd_last       : byte to queue and its end-of-packet marker
//   cmd_strobe          : enqueue request, ignored while cmd_busy
//   cmd_busy            : command FIFO full
//   ulpi_dir, ulpi_nxt  : PHY bus direction and throttle
//   ulpi_data_i/_o/_oe  : ULPI data bus input, output and link output enable
//   ulpi_stp            : end-of-packet strobe towards the PHY
//   rx_data, rx_valid   : received USB data byte, one-cycle valid per byte
//   rx_cmd, rx_cmd_valid: latest RX CMD byte (held) and its update pulse
//   rx_active           : PHY owns the bus and the turnaround is over
// ---------------------------------------------------------------------------
module ulpi_link_buf
    import ulpi_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] cmd,
    input  logic              cmd_last,
    input  logic              cmd_strobe,
    output logic              cmd_busy,
    input  logic              ulpi_dir,
    input  logic              ulpi_nxt,
    input  logic [DATA_W-1:0] ulpi_data_i,
    output logic [DATA_W-1:0] ulpi_data_o,
    output logic              ulpi_data_oe,
    output logic              ulpi_stp,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_cmd,
    output logic              rx_cmd_valid,
    output logic              rx_active
);

    if (DATA_W != 8) begin : g_bad_width
        $error("ulpi_link_buf: only DATA_W = 8 is supported");
    end

    ulpi_bus_state_t state;
    ulpi_bus_state_t state_nxt;

    cmd_entry_t fifo_head;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_pop;
    logic       drive;

    ulpi_cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_strobe),
        .push_data ('{last: cmd_last, data: cmd}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign cmd_busy = fifo_full;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A rising dir always wins over transmit progress,
    // except in STP where the stp cycle is completed first.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ulpi_dir)         state_nxt = ST_TURN_IN;
                else if (!fifo_empty) state_nxt = ST_TX;
            end
            ST_TX: begin
                if (ulpi_dir)
                    state_nxt = ST_TURN_IN;
                else if (ulpi_nxt && !fifo_empty && fifo_head.last)
                    state_nxt = ST_STP;
            end
            ST_STP:      state_nxt = ulpi_dir ? ST_TURN_IN : ST_IDLE;
            ST_TURN_IN:  state_nxt = ulpi_dir ? ST_RX : ST_TURN_OUT;
            ST_RX:       state_nxt = ulpi_dir ? ST_RX : ST_TURN_OUT;
            ST_TURN_OUT: state_nxt = ulpi_dir ? ST_RX : ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Output logic. With the FIFO drained mid-packet TX keeps the bus at the
    // idle byte until the next entry arrives.
    always_comb begin
        drive       = 1'b0;
        ulpi_data_o = ULPI_IDLE_BYTE;
        ulpi_stp    = 1'b0;
        fifo_pop    = 1'b0;
        case (state)
            ST_IDLE: drive = 1'b1;
            ST_TX: begin
                drive    = 1'b1;
                if (!fifo_empty) ulpi_data_o = fifo_head.data;
                fifo_pop = !ulpi_dir && ulpi_nxt && !fifo_empty;
            end
            ST_STP: begin
                drive    = 1'b1;
                ulpi_stp = 1'b1;
            end
            default: ;
        endcase
    end

    // The enable drops combinationally with dir so the link never fights the
    // PHY, and is held low while reset is asserted.
    assign ulpi_data_oe = drive && !ulpi_dir && !reset;
    assign rx_active    = (state == ST_RX) && ulpi_dir;

    // RX decode: nxt separates USB data bytes from RX CMD status bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_cmd       <= '0;
            rx_cmd_valid <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_cmd_valid <= 1'b0;
            if (state == ST_RX && ulpi_dir) begin
                if (ulpi_nxt) begin
                    rx_data  <= ulpi_data_i;
                    rx_valid <= 1'b1;
                end else begin
                    rx_cmd       <= ulpi_data_i;
                    rx_cmd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ulpi_link_buf.sv
// ---------------------------------------------------------------------------
// tb_ulpi_link_buf
// Directed, table-driven bench for ulpi_link_buf. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ulpi_link_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cmd;
    logic       cmd_last;
    logic       cmd_strobe;
    logic       cmd_busy;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic [7:0] ulpi_data_i;
    logic [7:0] ulpi_data_o;
    logic       ulpi_data_oe;
    logic       ulpi_stp;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] rx_cmd;
    logic       rx_cmd_valid;
    logic       rx_active;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ulpi_link_buf #(
        .CMD_DEPTH (4),
        .DATA_W    (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cmd),
        .cmd_last     (cmd_last),
        .cmd_strobe   (cmd_strobe),
        .cmd_busy     (cmd_busy),
        .ulpi_dir     (ulpi_dir),
        .ulpi_nxt     (ulpi_nxt),
        .ulpi_data_i  (ulpi_data_i),
        .ulpi_data_o  (ulpi_data_o),
        .ulpi_data_oe (ulpi_data_oe),
        .ulpi_stp     (ulpi_stp),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_cmd       (rx_cmd),
        .rx_cmd_valid (rx_cmd_valid),
        .rx_active    (rx_active)
    );

    typedef struct {
        logic       dir;
        logic       nxt;
        logic [7:0] din;
        logic       strobe;
        logic [7:0] cmd;
        logic       last;
        logic       oe;
        logic [7:0] dout;
        logic       stp;
        logic       rxv;
        logic [7:0] rxd;
        logic       rxcv;
        logic [7:0] rxc;
        logic       rxa;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic dir, input logic nxt, input logic [7:0] din,
                       input logic strobe, input logic [7:0] c, input logic last,
                       input logic oe, input logic [7:0] dout, input logic stp,
                       input logic rxv, input logic [7:0] rxd, input logic rxcv,
                       input logic [7:0] rxc, input logic rxa);
        vec_t v;
        v.dir = dir;   v.nxt = nxt;   v.din = din;
        v.strobe = strobe; v.cmd = c; v.last = last;
        v.oe = oe;     v.dout = dout; v.stp = stp;
        v.rxv = rxv;   v.rxd = rxd;   v.rxcv = rxcv;
        v.rxc = rxc;   v.rxa = rxa;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of the hand-written sequences: sample mid-cycle, then advance.
    task automatic cyc(input string tag, input logic oe, input logic [7:0] dout,
                       input logic stp, input logic busy);
        @(negedge clk);
        check({tag, " oe"},   {31'd0, ulpi_data_oe}, {31'd0, oe});
        check({tag, " data"}, {24'd0, ulpi_data_o},  {24'd0, dout});
        check({tag, " stp"},  {31'd0, ulpi_stp},     {31'd0, stp});
        check({tag, " busy"}, {31'd0, cmd_busy},     {31'd0, busy});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        cmd         = 8'h00;
        cmd_last    = 1'b0;
        cmd_strobe  = 1'b0;
        ulpi_dir    = 1'b0;
        ulpi_nxt    = 1'b0;
        ulpi_data_i = 8'h00;

        //   dir nxt din    stb cmd    lst | oe dout  stp rxv rxd    rxcv rxc    rxa
        // idle after reset
        for (int i = 0; i < 3; i++)
            add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        // 3-byte packet, nxt 1,0,1,1 -> 41,55,55,66 then stp
        add(0, 0, 8'h00, 1, 8'h41, 0,   1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 1, 8'h55, 0,   1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0, 1, 8'h00, 1, 8'h66, 1,   1, 8'h41, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h55, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0, 1, 8'h00, 0, 8'h00, 0,   1, 8'h55, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0, 1, 8'h00, 0, 8'h00, 0,   1, 8'h66, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        // dir rises while 55 is held; RX CMD 4D; 55 re-driven afterwards
        add(0, 0, 8'h00, 1, 8'h55, 0,   1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 1, 8'h77, 1,   1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h55, 0, 0, 8'h00, 0, 8'h00, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h55, 0, 0, 8'h00, 0, 8'h00, 0);
        add(1, 0, 8'hFF, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        add(1, 0, 8'h4D, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1);
        add(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 1, 8'h4D, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 0, 8'h4D, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 0, 0, 8'h00, 0, 8'h4D, 0);
        add(0, 1, 8'h00, 0, 8'h00, 0,   1, 8'h55, 0, 0, 8'h00, 0, 8'h4D, 0);
        add(0, 1, 8'h00, 0, 8'h00, 0,   1, 8'h77, 0, 0, 8'h00, 0, 8'h4D, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 1, 0, 8'h00, 0, 8'h4D, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 0, 0, 8'h00, 0, 8'h4D, 0);
        // RX stream: nxt 0,1,1,1,0 with 4D,A1,A2,A3,4E
        add(1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 0, 8'h4D, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 0, 8'h4D, 0);
        add(1, 0, 8'h4D, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 0, 8'h4D, 1);
        add(1, 1, 8'hA1, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 1, 8'h4D, 1);
        add(1, 1, 8'hA2, 0, 8'h00, 0,   0, 8'h00, 0, 1, 8'hA1, 0, 8'h4D, 1);
        add(1, 1, 8'hA3, 0, 8'h00, 0,   0, 8'h00, 0, 1, 8'hA2, 0, 8'h4D, 1);
        add(1, 0, 8'h4E, 0, 8'h00, 0,   0, 8'h00, 0, 1, 8'hA3, 0, 8'h4D, 1);
        add(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'hA3, 1, 8'h4E, 0);
        // dir back high during TURN_OUT: straight to RX
        add(1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'hA3, 0, 8'h4E, 0);
        add(1, 0, 8'h5A, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'hA3, 0, 8'h4E, 1);
        add(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'hA3, 1, 8'h5A, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'hA3, 0, 8'h5A, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 0, 0, 8'hA3, 0, 8'h5A, 0);

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset oe",      {31'd0, ulpi_data_oe}, 32'd0);
        check("reset data",    {24'd0, ulpi_data_o},  32'd0);
        check("reset stp",     {31'd0, ulpi_stp},     32'd0);
        check("reset busy",    {31'd0, cmd_busy},     32'd0);
        check("reset rxv",     {31'd0, rx_valid},     32'd0);
        check("reset rxcv",    {31'd0, rx_cmd_valid}, 32'd0);
        check("reset rxa",     {31'd0, rx_active},    32'd0);
        check("reset rx_data", {24'd0, rx_data},      32'd0);
        check("reset rx_cmd",  {24'd0, rx_cmd},       32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            ulpi_dir    = vecs[i].dir;
            ulpi_nxt    = vecs[i].nxt;
            ulpi_data_i = vecs[i].din;
            cmd_strobe  = vecs[i].strobe;
            cmd         = vecs[i].cmd;
            cmd_last    = vecs[i].last;
            @(negedge clk);
            check($sformatf("row%0d oe", i),      {31'd0, ulpi_data_oe}, {31'd0, vecs[i].oe});
            check($sformatf("row%0d data", i),    {24'd0, ulpi_data_o},  {24'd0, vecs[i].dout});
            check($sformatf("row%0d stp", i),     {31'd0, ulpi_stp},     {31'd0, vecs[i].stp});
            check($sformatf("row%0d busy", i),    {31'd0, cmd_busy},     32'd0);
            check($sformatf("row%0d rxv", i),     {31'd0, rx_valid},     {31'd0, vecs[i].rxv});
            check($sformatf("row%0d rx_data", i), {24'd0, rx_data},      {24'd0, vecs[i].rxd});
            check($sformatf("row%0d rxcv", i),    {31'd0, rx_cmd_valid}, {31'd0, vecs[i].rxcv});
            check($sformatf("row%0d rx_cmd", i),  {24'd0, rx_cmd},       {24'd0, vecs[i].rxc});
            check($sformatf("row%0d rxa", i),     {31'd0, rx_active},    {31'd0, vecs[i].rxa});
            @(posedge clk);
            #1;
        end
        ulpi_dir    = 1'b0;
        ulpi_nxt    = 1'b0;
        ulpi_data_i = 8'h00;

        // Fill the FIFO with nxt low; fifth strobe must be dropped.
        cmd_strobe = 1'b1; cmd = 8'hA0; cmd_last = 1'b0; cyc("fill0", 1, 8'h00, 0, 0);
        cmd = 8'hA1;                                     cyc("fill1", 1, 8'h00, 0, 0);
        cmd = 8'hA2;                                     cyc("fill2", 1, 8'hA0, 0, 0);
        cmd = 8'hA3; cmd_last = 1'b1;                    cyc("fill3", 1, 8'hA0, 0, 0);
        cmd = 8'hA4;                                     cyc("fill4", 1, 8'hA0, 0, 1);
        cmd_strobe = 1'b0; ulpi_nxt = 1'b1;              cyc("fill5", 1, 8'hA0, 0, 1);
        cyc("fill6", 1, 8'hA1, 0, 0);
        cyc("fill7", 1, 8'hA2, 0, 0);
        cyc("fill8", 1, 8'hA3, 0, 0);
        ulpi_nxt = 1'b0;
        cyc("fill9", 1, 8'h00, 1, 0);
        cyc("fill10", 1, 8'h00, 0, 0);
        cyc("fill11", 1, 8'h00, 0, 0);

        // Reset in the middle of a 3-byte packet.
        cmd_strobe = 1'b1; cmd = 8'hB1; cmd_last = 1'b0; cyc("rst0", 1, 8'h00, 0, 0);
        cmd = 8'hB2;                                     cyc("rst1", 1, 8'h00, 0, 0);
        cmd = 8'hB3; cmd_last = 1'b1; ulpi_nxt = 1'b1;   cyc("rst2", 1, 8'hB1, 0, 0);
        cmd_strobe = 1'b0; ulpi_nxt = 1'b0;
        @(negedge clk);
        check("rst3 data", {24'd0, ulpi_data_o}, 32'h0000_00B2);
        #1;
        reset = 1'b1;
        #1;
        check("rst async oe",   {31'd0, ulpi_data_oe}, 32'd0);
        check("rst async data", {24'd0, ulpi_data_o},  32'd0);
        check("rst async stp",  {31'd0, ulpi_stp},     32'd0);
        check("rst async busy", {31'd0, cmd_busy},     32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst hold oe",  {31'd0, ulpi_data_oe}, 32'd0);
        check("rst hold stp", {31'd0, ulpi_stp},     32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ulpi_nxt = 1'b1;
        cyc("post0", 1, 8'h00, 0, 0);
        cyc("post1", 1, 8'h00, 0, 0);
        cyc("post2", 1, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
